// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants for the Common Data Bus arbiter.
// FU codes, default widths and the FU-code to requester-index mapping.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU = 5;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 8;

  localparam logic [2:0] FU_ALU  = 3'd1;
  localparam logic [2:0] FU_MEM  = 3'd2;
  localparam logic [2:0] FU_MUL  = 3'd3;
  localparam logic [2:0] FU_DIV  = 3'd4;
  localparam logic [2:0] FU_JUMP = 3'd5;

  function automatic int fu_index(input logic [2:0] code);
    return int'(code) - 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: first set request at or after a start index, wrapping.
// Returns one-hot grant, its index and an any-request flag.
module rr_picker #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // circular scan from start, first hit wins
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result slots arbitrated onto the CDB.
// Define CDB_RR_EN for round-robin; default is fixed priority (ALU first).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        fu_finish,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*32-1:0]     fu_pc,
  output logic [NUM_FU-1:0]        fu_hold,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [31:0]              cdb_pc,
  output logic [NUM_FU-1:0]        cdb_grant,
  output logic                     proto_err
);

  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] valid;
  logic [TAG_W-1:0]  tag_q  [NUM_FU];
  logic [DATA_W-1:0] data_q [NUM_FU];
  logic [31:0]       pc_q   [NUM_FU];

  logic [NUM_FU-1:0] grant;
  logic [IW-1:0]     idx;
  logic              any;
  logic [IW-1:0]     start;
  logic [NUM_FU-1:0] accept;
  logic [NUM_FU-1:0] clash;

`ifdef CDB_RR_EN
  logic [IW-1:0] ptr;

  // remember the last granted requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= IW'(NUM_FU - 1);
    else if (any)
      ptr <= idx;
  end

  assign start = (ptr == IW'(NUM_FU - 1)) ? '0 : ptr + 1'b1;
`else
  assign start = '0;
`endif

  rr_picker #(.N(NUM_FU)) u_pick (
    .req   (valid),
    .start (start),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // a slot takes a new result if empty or leaving this cycle
  assign accept = fu_finish & (~valid | grant);
  assign clash  = fu_finish & valid & ~grant;

  // slot storage: refill wins over clear on a granted slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          valid[i]  <= 1'b1;
          tag_q[i]  <= fu_tag[i*TAG_W +: TAG_W];
          data_q[i] <= fu_data[i*DATA_W +: DATA_W];
          pc_q[i]   <= fu_pc[i*32 +: 32];
        end else if (grant[i]) begin
          valid[i]  <= 1'b0;
          tag_q[i]  <= '0;
          data_q[i] <= '0;
          pc_q[i]   <= '0;
        end
      end
      if (|clash)
        proto_err <= 1'b1;
    end
  end

  // broadcast the granted slot, zeros when idle
  always_comb begin
    cdb_valid = any;
    cdb_grant = grant;
    cdb_tag   = '0;
    cdb_data  = '0;
    cdb_pc    = '0;
    if (any) begin
      cdb_tag  = tag_q[idx];
      cdb_data = data_q[idx];
      cdb_pc   = pc_q[idx];
    end
  end

  assign fu_hold = valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter.
// Expected broadcasts are queued at stimulus time and popped by a monitor.
module tb_cdb_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    fu_finish = '0;
  logic [N*DW-1:0] fu_data = '0;
  logic [N*TW-1:0] fu_tag = '0;
  logic [N*32-1:0] fu_pc = '0;
  logic [N-1:0]    fu_hold;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [31:0]     cdb_pc;
  logic [N-1:0]    cdb_grant;
  logic            proto_err;

  cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fu_finish (fu_finish),
    .fu_data   (fu_data),
    .fu_tag    (fu_tag),
    .fu_pc     (fu_pc),
    .fu_hold   (fu_hold),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_pc    (cdb_pc),
    .cdb_grant (cdb_grant),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [31:0]   pc;
    logic [N-1:0]  grant;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int i, input logic [TW-1:0] tag,
                      input logic [DW-1:0] data, input logic [31:0] pc);
    exp_t e;
    e.tag   = tag;
    e.data  = data;
    e.pc    = pc;
    e.grant = N'(1 << i);
    sb.push_back(e);
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] tag,
                        input logic [DW-1:0] data, input logic [31:0] pc);
    fu_tag[i*TW +: TW]  = tag;
    fu_data[i*DW +: DW] = data;
    fu_pc[i*32 +: 32]   = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fu_finish = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // monitor: pop on every broadcast, idle outputs must be zero
  always @(negedge clk) begin
    if (!rst) begin
      if (cdb_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bcast", {56'd0, cdb_tag}, 64'hdead);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bcast_tag", 64'(cdb_tag), 64'(e.tag));
          chk("bcast_data", 64'(cdb_data), 64'(e.data));
          chk("bcast_pc", 64'(cdb_pc), 64'(e.pc));
          chk("bcast_grant", 64'(cdb_grant), 64'(e.grant));
        end
      end else begin
        chk("idle_zero", {cdb_tag, cdb_data, cdb_pc, cdb_grant},
            '0);
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb", {cdb_tag, cdb_data, cdb_pc, cdb_grant}, '0);
    chk("rst_hold", 64'(fu_hold), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    do_reset();

    // single ALU finish
    step();
    set_fu(0, 8'h11, 32'h5, 32'h10);
    fu_finish = 5'b00001;
    push(0, 8'h11, 32'h5, 32'h10);
    @(negedge clk);
    chk("t1_hold_t", 64'(fu_hold[0]), 64'd0);
    step();
    fu_finish = '0;
    @(negedge clk);
    chk("t1_hold_t1", 64'(fu_hold[0]), 64'd1);
    step();
    @(negedge clk);
    chk("t1_hold_t2", 64'(fu_hold[0]), 64'd0);
    drain("t1_drain");

    // all five at once, tags 1..5
    do_reset();
    step();
    for (int i = 0; i < N; i++) begin
      set_fu(i, TW'(i + 1), DW'(100 + i), 32'(200 + 4 * i));
      push(i, TW'(i + 1), DW'(100 + i), 32'(200 + 4 * i));
    end
    fu_finish = 5'b11111;
    step();
    fu_finish = '0;
    for (int k = 0; k <= N; k++) begin
      logic [N-1:0] m;
      m = 5'b11111 << k;
      @(negedge clk);
      chk("t2_hold", 64'(fu_hold), 64'(m));
      step();
    end
    drain("t2_drain");

    // ALU keeps refilling while MUL waits
    do_reset();
    step();
    set_fu(0, 8'ha1, 32'h1, 32'h100);
    set_fu(2, 8'hc3, 32'h3, 32'h300);
    fu_finish = 5'b00101;
    push(0, 8'ha1, 32'h1, 32'h100);
`ifdef CDB_RR_EN
    push(2, 8'hc3, 32'h3, 32'h300);
    step();
    set_fu(0, 8'ha2, 32'h2, 32'h104);
    fu_finish = 5'b00001;
    push(0, 8'ha2, 32'h2, 32'h104);
    step();
    fu_finish = '0;
    step();
    set_fu(0, 8'ha3, 32'h4, 32'h108);
    fu_finish = 5'b00001;
    push(0, 8'ha3, 32'h4, 32'h108);
    step();
    fu_finish = '0;
`else
    for (int k = 2; k <= 4; k++) begin
      step();
      set_fu(0, TW'(8'ha0 + k), DW'(k), 32'(32'h100 + 4 * k));
      fu_finish = 5'b00001;
      push(0, TW'(8'ha0 + k), DW'(k), 32'(32'h100 + 4 * k));
    end
    step();
    fu_finish = '0;
    push(2, 8'hc3, 32'h3, 32'h300);
`endif
    drain("t3_drain");

    // grant and refill in the same cycle
    do_reset();
    step();
    set_fu(0, 8'h21, 32'h7, 32'h20);
    fu_finish = 5'b00001;
    push(0, 8'h21, 32'h7, 32'h20);
    step();
    set_fu(0, 8'h22, 32'h8, 32'h24);
    fu_finish = 5'b00001;
    push(0, 8'h22, 32'h8, 32'h24);
    step();
    fu_finish = '0;
    @(negedge clk);
    chk("t4_nobubble", {cdb_valid, cdb_tag}, {1'b1, 8'h22});
    chk("t4_perr", 64'(proto_err), 64'd0);
    drain("t4_drain");

    // finish into an occupied, ungranted slot (MEM tag 0 wins first)
    do_reset();
    step();
    set_fu(1, 8'h00, 32'h33, 32'h40);
    set_fu(3, 8'h44, 32'h55, 32'h50);
    fu_finish = 5'b01010;
    push(1, 8'h00, 32'h33, 32'h40);
    push(3, 8'h44, 32'h55, 32'h50);
    step();
    set_fu(3, 8'h99, 32'h66, 32'h60);
    fu_finish = 5'b01000;
    @(negedge clk);
    chk("t5_perr_before", 64'(proto_err), 64'd0);
    step();
    fu_finish = '0;
    @(negedge clk);
    chk("t5_perr_set", 64'(proto_err), 64'd1);
    drain("t5_drain");
    chk("t5_perr_sticky", 64'(proto_err), 64'd1);

    // async reset with three slots pending
    step();
    set_fu(0, 8'h61, 32'h1, 32'h70);
    set_fu(2, 8'h63, 32'h3, 32'h78);
    set_fu(4, 8'h65, 32'h5, 32'h80);
    fu_finish = 5'b10101;
    push(0, 8'h61, 32'h1, 32'h70);
    step();
    fu_finish = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(cdb_valid), 64'd0);
    chk("t6_cdb", {cdb_tag, cdb_data, cdb_pc, cdb_grant}, '0);
    chk("t6_hold", 64'(fu_hold), 64'd0);
    chk("t6_perr", 64'(proto_err), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t6_hold_after", 64'(fu_hold), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter for the Tomasulo core. Captures one completed result per functional unit (ALU, MEM, MUL, DIV, JUMP) into a per-FU holding slot. Grants exactly one slot per cycle onto the CDB as the (tag, data, pc) broadcast. Back-pressures each FU with a hold signal until its result has been broadcast.

## Interface
Parameters:
- NUM_FU, 5: number of requesters; requester i corresponds to FU code i+1 (ALU=0, MEM=1, MUL=2, DIV=3, JUMP=4).
- DATA_W, 32: result width.
- TAG_W, 8: RS tag width; tag 0 means "no producer".

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  main clock
- rst  in  1  asynchronous active-high reset
- fu_finish  in  NUM_FU  one-cycle finish pulse per FU
- fu_data  in  NUM_FU*DATA_W  result per FU, packed, FU i at [i*DATA_W +: DATA_W]
- fu_tag  in  NUM_FU*TAG_W  RS entry tag of the producing instruction
- fu_pc  in  NUM_FU*32  instruction PC (debug/wb trace)
- fu_hold  out  NUM_FU  slot i occupied; FU i must keep EN low
- cdb_valid  out  1  broadcast valid this cycle
- cdb_tag  out  TAG_W  broadcast tag, 0 when invalid
- cdb_data  out  DATA_W  broadcast data, 0 when invalid
- cdb_pc  out  32  broadcast PC, 0 when invalid
- cdb_grant  out  NUM_FU  one-hot granted slot, 0 when invalid
- proto_err  out  1  sticky: finish received into an occupied, ungranted slot

## Operation
- Each slot holds: valid, tag, data, pc. On reset, all slots are invalid and all fields are 0.
- Capture: if fu_finish[i] is high, the slot loads at the clock edge. The slot must be empty, or be granted in the same cycle.
- Protocol violation: if fu_finish[i] arrives while slot i is valid and not granted, the pulse is dropped and the slot keeps its old contents. proto_err is set and stays set until rst.
- Grant: combinational select over the valid slots; at most one grant bit is set.
- The granted slot drives the cdb_* outputs. It is cleared at the next edge unless it is refilled in that same cycle.
- fu_hold[i] = slot valid[i]; it is registered state only, with no combinational path from fu_finish.
- A finish with tag 0 is captured and broadcast like any other. Consumers ignore it (e.g. store/branch with no rd).
- Idle: when no slot is valid, cdb_valid=0 and every cdb_* output is 0.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_pc=0, cdb_grant=0, fu_hold=0, proto_err=0, RR pointer=NUM_FU-1.
- Latency: fu_finish in cycle t → slot valid in t+1 → earliest broadcast in t+1 → fu_hold low in t+2 if granted in t+1.
- Worst-case wait with NUM_FU simultaneous finishes: NUM_FU cycles under round-robin. Under fixed priority, the wait is unbounded for the lowest priority.
- Same slot, grant and refill in the same cycle: the new result is captured and slot valid stays 1. This gives back-to-back broadcasts from one FU with no bubble.
- Asynchronous rst mid-operation: all pending results are discarded immediately and the outputs go to their reset values.

## Configuration
- CDB_RR_EN defined: round-robin arbitration.
  - A pointer register holds the last granted index.
  - The search starts at pointer+1 mod NUM_FU.
  - The pointer updates only on a valid grant.
- CDB_RR_EN undefined: fixed priority, lowest index first (ALU > MEM > MUL > DIV > JUMP). There is no pointer register.

## Structure
- Shared package/header:
  - FU code constants FU_ALU=1, FU_MEM=2, FU_MUL=3, FU_DIV=4, FU_JUMP=5.
  - NUM_FU, TAG_W, DATA_W defaults.
  - The requester-index = FU code − 1 mapping.
- One sub-module, rr_picker: takes a request vector and a start index, and returns a one-hot grant plus the grant index. In fixed mode it is instantiated with start index tied to 0.

## Test plan
- Single finish: ALU finish tag=8'h11 data=32'h5 pc=32'h10 at t → cdb_valid=1, tag 8'h11, data 5, pc 32'h10 at t+1. fu_hold[0]=1 at t+1 and 0 at t+2.
- All five finish at t, tags 1..5:
  - CDB_RR_EN, pointer at reset: tags 1,2,3,4,5 at t+1..t+5.
  - Fixed priority: the same order, and each fu_hold drops the cycle after its grant.
- Fairness (CDB_RR_EN only): ALU re-finishes every grant cycle while MUL is pending. MUL is broadcast no later than the 2nd cycle after capture. Fixed mode: MUL starves while ALU keeps refilling.
- Grant+refill: ALU slot granted at t while a new ALU finish (tag 8'h22) arrives at t. Tag 8'h22 is broadcast at t+1 with no idle cycle and proto_err stays 0.
- Violation: MEM slot valid and DIV slot valid, fixed mode so MEM wins; then DIV finish arrives again → pulse dropped, proto_err=1, original DIV data still broadcast.
- Reset mid-operation: three slots valid, assert rst → all outputs 0 immediately. After release, no stale broadcast appears.
